// File: rtl/buffer_memwb_skid_if.sv
// rtl/buffer_memwb_skid_if.sv - MEM-side and WB-side handshake bundle for buffer_memwb_skid
// slave is the buffer's view; master is the view of whatever drives MEM and consumes WB.
interface buffer_memwb_skid_if #(
   parameter int DATA_W = 16,
   parameter int BYTE_W = 8,
   parameter int CTRL_W = 1
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_word;
   logic [BYTE_W-1:0] in_byte;
   logic [DATA_W-1:0] in_fwd;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_word;
   logic [BYTE_W-1:0] out_byte;
   logic [DATA_W-1:0] out_fwd;
   logic [CTRL_W-1:0] out_ctrl;

   modport slave (
      input  in_valid, in_word, in_byte, in_fwd, in_ctrl, flush, out_ready,
      output in_ready, out_valid, out_word, out_byte, out_fwd, out_ctrl
   );

   modport master (
      output in_valid, in_word, in_byte, in_fwd, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, out_word, out_byte, out_fwd, out_ctrl
   );
endinterface

// File: rtl/buffer_memwb_skid.sv
// rtl/buffer_memwb_skid.sv - MEM/WB pipeline buffer with 2-entry skid and registered in_ready
// Optional stall counter output enabled by BUFFER_MEMWB_STALLCNT_EN.
module buffer_memwb_skid #(
   parameter int DATA_W = 16,
   parameter int BYTE_W = 8,
   parameter int CTRL_W = 1
) (
   input  logic                   C,
   input  logic                   R,
`ifdef BUFFER_MEMWB_STALLCNT_EN
   output logic [15:0]            stall_cnt,
`endif
   buffer_memwb_skid_if.slave     bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MAIN  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_out_valid;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_out_word;
   logic [BYTE_W-1:0] r_out_byte;
   logic [DATA_W-1:0] r_out_fwd;
   logic [CTRL_W-1:0] r_out_ctrl;
   logic [DATA_W-1:0] r_skid_word;
   logic [BYTE_W-1:0] r_skid_byte;
   logic [DATA_W-1:0] r_skid_fwd;
   logic [CTRL_W-1:0] r_skid_ctrl;

   logic w_accept;
   logic w_drain;
   logic w_load_out;
   logic w_load_skid;
   logic w_skid_to_out;

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_drain  = r_out_valid & bus.out_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_load_out  = 1'b1;
               w_state_nxt = MAIN;
            end
         end
         MAIN: begin
            if (w_accept && w_drain) begin
               w_load_out = 1'b1;
            end else if (w_accept) begin
               w_load_skid = 1'b1;
               w_state_nxt = SKID;
            end else if (w_drain) begin
               w_state_nxt = EMPTY;
            end
         end
         SKID: begin
            if (w_drain) begin
               w_skid_to_out = 1'b1;
               w_state_nxt   = MAIN;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
      // Flush wins over any accept or drain in the same cycle
      if (bus.flush) begin
         w_state_nxt   = EMPTY;
         w_load_out    = 1'b0;
         w_load_skid   = 1'b0;
         w_skid_to_out = 1'b0;
      end
   end

   always_ff @(posedge C) begin
      if (!R) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_word  <= '0;
         r_out_byte  <= '0;
         r_out_fwd   <= '0;
         r_out_ctrl  <= '0;
         r_skid_word <= '0;
         r_skid_byte <= '0;
         r_skid_fwd  <= '0;
         r_skid_ctrl <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt != EMPTY);
         r_in_ready  <= (w_state_nxt != SKID);
         if (w_load_out) begin
            r_out_word <= bus.in_word;
            r_out_byte <= bus.in_byte;
            r_out_fwd  <= bus.in_fwd;
            r_out_ctrl <= bus.in_ctrl;
         end else if (w_skid_to_out) begin
            r_out_word <= r_skid_word;
            r_out_byte <= r_skid_byte;
            r_out_fwd  <= r_skid_fwd;
            r_out_ctrl <= r_skid_ctrl;
         end
         if (w_load_skid) begin
            r_skid_word <= bus.in_word;
            r_skid_byte <= bus.in_byte;
            r_skid_fwd  <= bus.in_fwd;
            r_skid_ctrl <= bus.in_ctrl;
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_word  = r_out_word;
   assign bus.out_byte  = r_out_byte;
   assign bus.out_fwd   = r_out_fwd;
   assign bus.out_ctrl  = r_out_ctrl;

`ifdef BUFFER_MEMWB_STALLCNT_EN
   logic [15:0] r_stall_cnt;

   // Counts stalled edges, saturating; flush deliberately leaves it alone
   always_ff @(posedge C) begin
      if (!R) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_buffer_memwb_skid.sv
// tb/tb_buffer_memwb_skid.sv - directed and random checks of buffer_memwb_skid against a FIFO model
// The model is a depth-2 queue of beats; in_ready means fewer than two beats are held.
module tb_buffer_memwb_skid;
   localparam int DATA_W = 16;
   localparam int BYTE_W = 8;
   localparam int CTRL_W = 1;
   localparam int BEAT_W = DATA_W + BYTE_W + DATA_W + CTRL_W;

   logic C;
   logic R;
   int   n_tests;
   int   n_fail;

   buffer_memwb_skid_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .CTRL_W(CTRL_W)) bus ();

`ifdef BUFFER_MEMWB_STALLCNT_EN
   logic [15:0] stall_cnt;
   int          m_cnt;
`endif

   buffer_memwb_skid #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .CTRL_W(CTRL_W)) dut (
      .C         (C),
      .R         (R),
`ifdef BUFFER_MEMWB_STALLCNT_EN
      .stall_cnt (stall_cnt),
`endif
      .bus       (bus)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   logic [BEAT_W-1:0] m_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [BEAT_W-1:0] b;
      chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
      chk("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
      if (m_q.size() > 0) begin
         b = m_q[0];
         chk("out_word", 32'(bus.out_word), 32'(b[BEAT_W-1 -: DATA_W]));
         chk("out_byte", 32'(bus.out_byte), 32'(b[BEAT_W-DATA_W-1 -: BYTE_W]));
         chk("out_fwd", 32'(bus.out_fwd), 32'(b[CTRL_W+DATA_W-1 -: DATA_W]));
         chk("out_ctrl", 32'(bus.out_ctrl), 32'(b[CTRL_W-1:0]));
      end
`ifdef BUFFER_MEMWB_STALLCNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
   endtask

   // Advance the model by one edge using the inputs currently driven, then sample after the edge
   task automatic cycle(input bit do_check);
      bit acc;
      bit drn;
      acc = bus.in_valid && (m_q.size() < 2);
      drn = (m_q.size() > 0) && bus.out_ready;
`ifdef BUFFER_MEMWB_STALLCNT_EN
      if (!R) m_cnt = 0;
      else if ((m_q.size() > 0) && !bus.out_ready && (m_cnt < 32'hFFFF)) m_cnt++;
`endif
      if (!R || bus.flush) begin
         m_q.delete();
      end else begin
         if (drn) void'(m_q.pop_front());
         if (acc) m_q.push_back({bus.in_word, bus.in_byte, bus.in_fwd, bus.in_ctrl});
      end
      @(posedge C);
      #1;
      if (do_check) check_model();
   endtask

   task automatic drive(input bit v, input logic [15:0] w, input bit ordy);
      bus.in_valid  = v;
      bus.in_word   = w;
      bus.in_byte   = w[7:0] ^ 8'h5A;
      bus.in_fwd    = ~w;
      bus.in_ctrl   = w[0];
      bus.out_ready = ordy;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
      chk({tag, "_word"}, 32'(bus.out_word), 32'h0);
      chk({tag, "_byte"}, 32'(bus.out_byte), 32'h0);
      chk({tag, "_fwd"}, 32'(bus.out_fwd), 32'h0);
      chk({tag, "_ctrl"}, 32'(bus.out_ctrl), 32'h0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
`ifdef BUFFER_MEMWB_STALLCNT_EN
      m_cnt = 0;
`endif
      R         = 1'b0;
      bus.flush = 1'b0;
      drive(1'b0, 16'h0000, 1'b1);
      cycle(1'b0);
      R = 1'b1;
      check_zero_outputs("reset");

      // Single beat with the exact field values
      bus.in_valid = 1'b1;
      bus.in_word  = 16'hA237;
      bus.in_byte  = 8'hF0;
      bus.in_fwd   = 16'hF500;
      bus.in_ctrl  = 1'b1;
      bus.out_ready = 1'b1;
      cycle(1'b1);
      chk("single_valid", 32'(bus.out_valid), 32'h1);
      chk("single_word", 32'(bus.out_word), 32'hA237);
      chk("single_byte", 32'(bus.out_byte), 32'hF0);
      chk("single_fwd", 32'(bus.out_fwd), 32'hF500);
      chk("single_ctrl", 32'(bus.out_ctrl), 32'h1);
      bus.in_valid = 1'b0;
      cycle(1'b1);
      chk("single_gone", 32'(bus.out_valid), 32'h0);

      // Back-to-back streaming
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 16'(i), 1'b1);
         cycle(1'b1);
         chk("stream_word", 32'(bus.out_word), 32'(i));
         chk("stream_ready", 32'(bus.in_ready), 32'h1);
      end
      drive(1'b0, 16'h0, 1'b1);
      cycle(1'b1);

      // Skid fill then drain in order
      drive(1'b1, 16'h8400, 1'b0);
      cycle(1'b1);
      drive(1'b1, 16'h8401, 1'b0);
      cycle(1'b1);
      chk("skid_word", 32'(bus.out_word), 32'h8400);
      chk("skid_ready", 32'(bus.in_ready), 32'h0);
      drive(1'b0, 16'h0, 1'b0);
      cycle(1'b1);
      chk("skid_hold", 32'(bus.out_word), 32'h8400);
      drive(1'b0, 16'h0, 1'b1);
      cycle(1'b1);
      chk("drain1_word", 32'(bus.out_word), 32'h8401);
      chk("drain1_ready", 32'(bus.in_ready), 32'h1);
      cycle(1'b1);
      chk("drain2_valid", 32'(bus.out_valid), 32'h0);

      // Flush while in SKID with a simultaneous beat
      drive(1'b1, 16'h1111, 1'b0);
      cycle(1'b1);
      drive(1'b1, 16'h2222, 1'b0);
      cycle(1'b1);
      chk("pre_flush_ready", 32'(bus.in_ready), 32'h0);
      drive(1'b1, 16'hBEEF, 1'b0);
      bus.flush = 1'b1;
      cycle(1'b1);
      bus.flush = 1'b0;
      chk("flush_valid", 32'(bus.out_valid), 32'h0);
      chk("flush_ready", 32'(bus.in_ready), 32'h1);
      drive(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1);

      // Reset with two beats held
      drive(1'b1, 16'h3333, 1'b0);
      cycle(1'b1);
      drive(1'b1, 16'h4444, 1'b0);
      cycle(1'b1);
      drive(1'b0, 16'h0, 1'b1);
      R = 1'b0;
      cycle(1'b0);
      R = 1'b1;
      check_zero_outputs("midreset");
      for (int i = 0; i < 3; i++) cycle(1'b1);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
         bus.flush = ($urandom_range(0, 31) == 0);
         R = ($urandom_range(0, 127) != 0);
         cycle(1'b1);
      end
      R         = 1'b1;
      bus.flush = 1'b0;

`ifdef BUFFER_MEMWB_STALLCNT_EN
      drive(1'b0, 16'h0, 1'b1);
      R = 1'b0;
      cycle(1'b1);
      R = 1'b1;
      drive(1'b1, 16'h5555, 1'b0);
      cycle(1'b1);
      drive(1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1);
      chk("stall5", 32'(stall_cnt), 32'd5);
      for (int i = 0; i < 65529; i++) cycle(1'b0);
      chk("stall_fffe", 32'(stall_cnt), 32'hFFFE);
      for (int i = 0; i < 3; i++) cycle(1'b1);
      chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
      bus.flush = 1'b1;
      cycle(1'b1);
      bus.flush = 1'b0;
      chk("stall_flush", 32'(stall_cnt), 32'hFFFF);
      R = 1'b0;
      cycle(1'b1);
      R = 1'b1;
      chk("stall_reset", 32'(stall_cnt), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/buffer_memwb_skid.md
Name: buffer_memwb_skid

Overview:
- Parametrised MEM/WB pipeline buffer with a valid/ready handshake and a 2-entry skid stage.
- Carries the loaded word, loaded byte, ALU forward value and control bits from the MEM stage to the WB stage.
- Supports back-pressure (WB stall) and a synchronous flush.
- Registers all WB-facing outputs and the MEM-facing ready, so no combinational path runs from out_ready to in_ready.

Parameters:
- DATA_W, 16, width of the word and forward fields.
- BYTE_W, 8, width of the byte field.
- CTRL_W, 1, width of the control field (bit 0 = reg-write enable).

Ports:
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous active-low reset, sampled on the rising edge of C.
- in_valid  input  1  MEM stage presents a beat.
- in_ready  output  1  buffer can accept a beat this cycle (registered).
- in_word  input  DATA_W  loaded word.
- in_byte  input  BYTE_W  loaded byte.
- in_fwd  input  DATA_W  ALU/forward value.
- in_ctrl  input  CTRL_W  control bits.
- flush  input  1  discard all held beats.
- out_valid  output  1  WB stage has a beat.
- out_ready  input  1  WB stage consumes the beat.
- out_word  output  DATA_W  registered word.
- out_byte  output  BYTE_W  registered byte.
- out_fwd  output  DATA_W  registered forward value.
- out_ctrl  output  CTRL_W  registered control bits.

Behaviour:
- Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States: EMPTY (no beat), MAIN (output register holds a beat), SKID (output register and skid register both hold beats).
- Reset (R=0 at edge): state EMPTY; out_valid=0; out_word/out_byte/out_fwd/out_ctrl=0; skid register=0; in_ready=1 from the first edge after R returns to 1. Reset mid-transfer drops all held beats.
- EMPTY: accept -> load output register, go to MAIN. Latency is 1 cycle from accept to out_valid=1.
- MAIN:
  - accept & drain -> load output register from input, stay MAIN.
  - accept & !drain -> store input in skid register, go to SKID, in_ready=0 next cycle.
  - !accept & drain -> EMPTY.
  - otherwise hold.
- SKID: in_ready=0.
  - drain -> move skid register to output register, go to MAIN, in_ready=1 next cycle.
  - no drain -> hold.
- Ordering: strict FIFO; no beat is dropped or duplicated without flush.
- Stall: while out_valid=1 and out_ready=0, all out_* are held bit-stable.
- in_ready depends only on registered state (1 in EMPTY/MAIN, 0 in SKID).
- Flush: at the edge, state -> EMPTY, out_valid=0, in_ready=1. Flush has priority over a simultaneous accept (the incoming beat is discarded) and over drain. Data registers need not clear on flush.
- Reset has priority over flush.
- Fields are stored at declared widths; no extension or truncation.
- Input fields with in_valid=0 are ignored (X-tolerant).

Optional Feature:
- Macro: BUFFER_MEMWB_STALLCNT_EN.
- When defined:
  - Adds output stall_cnt, 16 bits.
  - Increments on every edge with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then single beat: R=0 for 1 edge, then R=1; in_word=16'hA237, in_byte=8'hF0, in_fwd=16'hF500, in_ctrl=1, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_word=A237, out_byte=F0, out_fwd=F500, out_ctrl=1; following cycle out_valid=0.
- Back-to-back streaming: in_valid=1 with words 0001,0002,0003 on consecutive cycles, out_ready=1 -> outputs 0001,0002,0003 on consecutive cycles; in_ready stays 1 throughout.
- Skid fill: out_ready=0 and send words 8400 then 8401 -> out_word stays 8400, in_ready=0 after the second accept. Then set out_ready=1 -> 8400 then 8401 appear in order, and in_ready=1 one cycle after the first drain.
- Flush with simultaneous accept: buffer in SKID, assert flush with in_valid=1 and in_word=BEEF -> next cycle out_valid=0, in_ready=1; BEEF never appears at the output.
- Reset mid-operation: buffer holds 2 beats, pulse R=0 for 1 edge -> all out_*=0, out_valid=0, in_ready=1 after release; no stale beat appears later.
- With BUFFER_MEMWB_STALLCNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. Force the count to 16'hFFFE, then stall 3 more cycles -> stall_cnt=FFFF. Flush -> count unchanged. Reset -> 0.
